// File: rtl/lsu_mem_access.sv
// Load/store memory-access stage: latches one request, checks it, drives a
// word-addressed memory handshake with byte strobes, and returns the loaded
// word shifted so the addressed byte/halfword lands at bit 0.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  // request side
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              isStore,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       storeData,
  // memory side
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [3:0]        memWstrb,
  output logic [31:0]       memWdata,
  input  logic              memReady,
  input  logic              memRvalid,
  input  logic [31:0]       memRdata,
  // response side
  output logic              rspValid,
  output logic [31:0]       dataMem,
  output logic              fault,
  output logic              busErr
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STRB_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ACCESS = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // state and latched request
  state_t              r_state,      w_state_nxt;
  logic                r_is_store,   w_is_store_nxt;
  logic [2:0]          r_funct3,     w_funct3_nxt;
  logic [ADDR_W-1:0]   r_addr,       w_addr_nxt;
  logic [DATA_W-1:0]   r_store_data, w_store_data_nxt;
  logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
  logic                r_fault_p,    w_fault_p_nxt;
  logic                r_berr_p,     w_berr_p_nxt;

  // registered outputs
  logic                r_req_ready,  w_req_ready_nxt;
  logic                r_mem_req,    w_mem_req_nxt;
  logic                r_mem_we,     w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr,   w_mem_addr_nxt;
  logic [STRB_W-1:0]   r_mem_wstrb,  w_mem_wstrb_nxt;
  logic [DATA_W-1:0]   r_mem_wdata,  w_mem_wdata_nxt;
  logic                r_rsp_valid,  w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_data_mem,   w_data_mem_nxt;
  logic                r_fault,      w_fault_nxt;
  logic                r_bus_err,    w_bus_err_nxt;

  // decode of the latched request
  logic [1:0]          w_off;
  logic                w_illegal;
  logic                w_misalign;
  logic [STRB_W-1:0]   w_lane_strb;
  logic [DATA_W-1:0]   w_lane_wdata;

  assign w_off = r_addr[1:0];

  // Legality, alignment and store lane placement for the latched request.
  always_comb begin
    w_illegal    = 1'b0;
    w_misalign   = 1'b0;
    w_lane_strb  = 4'b1111;
    w_lane_wdata = r_store_data;

    if (r_is_store) begin
      // stores only have B, H, W
      w_illegal = (r_funct3[2] == 1'b1) || (r_funct3 == 3'b011);
    end else begin
      w_illegal = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) ||
                  (r_funct3 == 3'b111);
    end

    case (r_funct3[1:0])
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = (w_off != 2'b00);
      default: w_misalign = 1'b0;
    endcase

    case (r_funct3[1:0])
      2'b00: begin
        w_lane_strb  = 4'b0001 << w_off;
        w_lane_wdata = {4{r_store_data[7:0]}};
      end
      2'b01: begin
        w_lane_strb  = 4'b0011 << w_off;
        w_lane_wdata = {2{r_store_data[15:0]}};
      end
      default: begin
        w_lane_strb  = 4'b1111;
        w_lane_wdata = r_store_data;
      end
    endcase
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    w_state_nxt      = r_state;
    w_is_store_nxt   = r_is_store;
    w_funct3_nxt     = r_funct3;
    w_addr_nxt       = r_addr;
    w_store_data_nxt = r_store_data;
    w_cnt_nxt        = r_cnt;
    w_fault_p_nxt    = r_fault_p;
    w_berr_p_nxt     = r_berr_p;
    w_req_ready_nxt  = r_req_ready;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_rsp_valid_nxt  = 1'b0;
    w_data_mem_nxt   = r_data_mem;
    w_fault_nxt      = r_fault;
    w_bus_err_nxt    = r_bus_err;

    case (r_state)
      S_IDLE: begin
        if (reqValid) begin
          w_is_store_nxt   = isStore;
          w_funct3_nxt     = funct3;
          w_addr_nxt       = addr;
          w_store_data_nxt = storeData;
          w_req_ready_nxt  = 1'b0;
          w_state_nxt      = S_CHECK;
        end
      end

      S_CHECK: begin
        w_fault_p_nxt = 1'b0;
        w_berr_p_nxt  = 1'b0;
        if (w_illegal || w_misalign) begin
          w_fault_p_nxt = 1'b1;
          w_state_nxt   = S_RESP;
        end else begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = r_is_store;
          w_mem_addr_nxt  = {r_addr[ADDR_W-1:2], 2'b00};
          w_mem_wstrb_nxt = r_is_store ? w_lane_strb : 4'b0000;
          w_mem_wdata_nxt = w_lane_wdata;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // memRvalid is deliberately not looked at here
        if (memReady) begin
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = 4'b0000;
          w_cnt_nxt       = r_cnt + CNT_W'(1);
          w_state_nxt     = r_is_store ? S_RESP : S_WAIT;
        end else if (r_cnt == CNT_LAST) begin
          w_mem_req_nxt   = 1'b0;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = 4'b0000;
          w_berr_p_nxt    = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_WAIT: begin
        if (memRvalid) begin
          w_data_mem_nxt = memRdata >> {w_off, 3'b000};
          w_state_nxt    = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_berr_p_nxt = 1'b1;
          w_state_nxt  = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        w_rsp_valid_nxt = 1'b1;
        w_fault_nxt     = r_fault_p;
        w_bus_err_nxt   = r_berr_p;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end

      default: begin
        w_mem_req_nxt   = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_wstrb_nxt = 4'b0000;
        w_req_ready_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  // State, request latch and output registers; reset aborts any access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_store_data <= '0;
      r_cnt        <= '0;
      r_fault_p    <= 1'b0;
      r_berr_p     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_data_mem   <= '0;
      r_fault      <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_store   <= w_is_store_nxt;
      r_funct3     <= w_funct3_nxt;
      r_addr       <= w_addr_nxt;
      r_store_data <= w_store_data_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fault_p    <= w_fault_p_nxt;
      r_berr_p     <= w_berr_p_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_data_mem   <= w_data_mem_nxt;
      r_fault      <= w_fault_nxt;
      r_bus_err    <= w_bus_err_nxt;
    end
  end

  assign reqReady = r_req_ready;
  assign memReq   = r_mem_req;
  assign memWe    = r_mem_we;
  assign memAddr  = r_mem_addr;
  assign memWstrb = r_mem_wstrb;
  assign memWdata = r_mem_wdata;
  assign rspValid = r_rsp_valid;
  assign dataMem  = r_data_mem;
  assign fault    = r_fault;
  assign busErr   = r_bus_err;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: a driver issues requests and plays the
// memory; a monitor pops expected responses from a queue on every rspValid.
module tb_lsu_mem_access;

  logic        clk;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memWstrb;
  logic [31:0] memWdata;
  logic        memReady;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        rspValid;
  logic [31:0] dataMem;
  logic        fault;
  logic        busErr;

  lsu_mem_access #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .isStore(isStore),
    .funct3(funct3), .addr(addr), .storeData(storeData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWstrb(memWstrb), .memWdata(memWdata),
    .memReady(memReady), .memRvalid(memRvalid), .memRdata(memRdata),
    .rspValid(rspValid), .dataMem(dataMem), .fault(fault), .busErr(busErr)
  );

  typedef struct {
    logic        f;
    logic        b;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  logic [31:0] last_data = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic void push(input logic f, input logic b, input logic [31:0] d, input int c);
    exp_t e;
    e.f = f; e.b = b; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  // Scoreboard monitor: every response must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rspValid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rspValid), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_fault", 32'(fault), 32'(e.f));
        chk("rsp_buserr", 32'(busErr), 32'(e.b));
        chk("rsp_data", dataMem, e.d);
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog expired");
  end

  // Present a request and wait for its accepting edge; inputs scrambled after.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, output int acc);
    int n;
    n = 0;
    isStore = st; funct3 = f3; addr = a; storeData = sd; reqValid = 1'b1;
    while (!reqReady && n < 40) begin @(posedge clk); #1; n++; end
    chk("req_ready_wait", 32'(reqReady), 32'h1);
    @(posedge clk); #1;
    acc = cyc;
    reqValid = 1'b0; isStore = ~st; funct3 = 3'b111;
    addr = 32'hFFFF_FFFF; storeData = ~sd;
  endtask

  // Play the memory for one access: check request, stall, accept, return data.
  task automatic serve(input int stall, input logic ld, input logic [31:0] rd, input logic junk,
                       input logic [31:0] eaddr, input logic ewe, input logic [3:0] estrb,
                       input logic [31:0] ewdata);
    int n;
    logic [69:0] snap;
    n = 0;
    while (!memReq && n < 20) begin @(posedge clk); #1; n++; end
    chk("mem_req", 32'(memReq), 32'h1);
    chk("mem_addr", memAddr, eaddr);
    chk("mem_we", 32'(memWe), 32'(ewe));
    chk("mem_wstrb", 32'(memWstrb), 32'(estrb));
    if (!ld) chk("mem_wdata", memWdata, ewdata);
    snap = {memReq, memWe, memWstrb, memAddr, memWdata};
    for (int i = 0; i < stall; i++) begin
      if (junk) begin memRvalid = 1'b1; memRdata = 32'hDEAD_DEAD; end
      @(posedge clk); #1;
      chk("mem_stable_hi", 32'(snap[69:32] ^ {memReq, memWe, memWstrb, memAddr}), 32'h0);
      chk("mem_stable_wd", memWdata, snap[31:0]);
    end
    memRvalid = 1'b0; memReady = 1'b1;
    @(posedge clk); #1;
    memReady = 1'b0;
    chk("mem_clear", 32'({memReq, memWe, memWstrb}), 32'h0);
    if (ld) begin
      memRvalid = 1'b1; memRdata = rd;
      @(posedge clk); #1;
      memRvalid = 1'b0; memRdata = 32'h0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic load_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input int stall, input logic junk, input logic [31:0] ed);
    int acc;
    issue(1'b0, f3, a, 32'h0, acc);
    last_data = ed;
    push(1'b0, 1'b0, ed, acc + 4 + stall);
    serve(stall, 1'b1, rd, junk, {a[31:2], 2'b00}, 1'b0, 4'b0000, 32'h0);
    wait_drain();
  endtask

  task automatic store_case(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd,
                            input int stall, input logic [3:0] estrb, input logic [31:0] ewd);
    int acc;
    issue(1'b1, f3, a, sd, acc);
    push(1'b0, 1'b0, last_data, acc + 3 + stall);
    serve(stall, 1'b0, 32'h0, 1'b0, {a[31:2], 2'b00}, 1'b1, estrb, ewd);
    wait_drain();
  endtask

  task automatic fault_case(input logic st, input logic [2:0] f3, input logic [31:0] a);
    int acc;
    logic seen;
    issue(st, f3, a, 32'h1234_5678, acc);
    push(1'b1, 1'b0, last_data, acc + 2);
    seen = memReq;
    repeat (3) begin @(posedge clk); #1; seen = seen | memReq; end
    chk("fault_no_memreq", 32'(seen), 32'h0);
    wait_drain();
  endtask

  initial begin : stim
    int acc;
    int acc_b;
    int nz;
    int n;
    int rc;
    rst = 1'b1;
    reqValid = 1'b0; isStore = 1'b0; funct3 = 3'b000; addr = 32'h0; storeData = 32'h0;
    memReady = 1'b0; memRvalid = 1'b0; memRdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(reqReady), 32'h1);
    chk("rst_mem", 32'({memReq, memWe, memWstrb}), 32'h0);
    chk("rst_mem_addr", memAddr, 32'h0);
    chk("rst_mem_wdata", memWdata, 32'h0);
    chk("rst_rsp", 32'({rspValid, fault, busErr}), 32'h0);
    chk("rst_data", dataMem, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // loads of each width and alignment, zero-wait unless stalled
    load_case(3'b000, 32'h0000_1003, 32'hAB12_3456, 0, 1'b0, 32'h0000_00AB);
    load_case(3'b001, 32'h0000_1002, 32'hAB12_3456, 3, 1'b1, 32'h0000_AB12);
    load_case(3'b010, 32'h0000_1004, 32'h1357_9BDF, 0, 1'b0, 32'h1357_9BDF);
    load_case(3'b100, 32'h0000_1001, 32'h00C0_FFEE, 0, 1'b0, 32'h0000_C0FF);
    load_case(3'b101, 32'h0000_1002, 32'h89AB_CDEF, 0, 1'b0, 32'h0000_89AB);

    // stores: lane strobes and replicated data
    store_case(3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 0, 4'b1100, 32'hBEEF_BEEF);
    store_case(3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5, 4'b1100, 32'hBEEF_BEEF);
    store_case(3'b000, 32'h0000_2001, 32'h1234_5677, 0, 4'b0010, 32'h7777_7777);
    store_case(3'b010, 32'h0000_200C, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);

    // misaligned and illegal requests
    fault_case(1'b0, 3'b010, 32'h0000_0006);
    fault_case(1'b1, 3'b100, 32'h0000_2000);
    fault_case(1'b0, 3'b011, 32'h0000_1000);
    fault_case(1'b0, 3'b001, 32'h0000_1001);
    fault_case(1'b1, 3'b010, 32'h0000_2002);

    // timeout: memory accepts the load but never returns data
    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, acc);
    push(1'b0, 1'b1, last_data, acc + 18);
    n = 0;
    while (!memReq && n < 20) begin @(posedge clk); #1; n++; end
    memReady = 1'b1;
    @(posedge clk); #1;
    memReady = 1'b0;
    wait_drain();
    chk("timeout_idle", 32'(reqReady), 32'h1);
    rc = rsp_cnt;
    memRvalid = 1'b1; memRdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    memRvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_rvalid_no_rsp", 32'(rsp_cnt), 32'(rc));

    // reset while waiting for read data
    issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, acc);
    n = 0;
    while (!memReq && n < 20) begin @(posedge clk); #1; n++; end
    memReady = 1'b1;
    @(posedge clk); #1;
    memReady = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_req_ready", 32'(reqReady), 32'h1);
    chk("arst_mem", 32'({memReq, memWe, memWstrb}), 32'h0);
    chk("arst_mem_addr", memAddr, 32'h0);
    chk("arst_rsp", 32'({rspValid, fault, busErr}), 32'h0);
    chk("arst_data", dataMem, 32'h0);
    last_data = 32'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    load_case(3'b000, 32'h0000_3001, 32'h0000_8000, 0, 1'b0, 32'h0000_0080);

    // back-to-back with reqValid held; memory answers immediately
    memReady = 1'b1; memRvalid = 1'b1; memRdata = 32'h5566_7788;
    isStore = 1'b0; funct3 = 3'b000; addr = 32'h0000_1002; reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    acc = cyc;
    push(1'b0, 1'b0, 32'h0000_5566, acc + 4);
    funct3 = 3'b010; addr = 32'h0000_1004;
    nz = 0;
    while (!reqReady && nz < 20) begin nz++; @(posedge clk); #1; end
    chk("b2b_ready_low_cycles", 32'(nz), 32'd4);
    @(posedge clk); #1;
    acc_b = cyc;
    reqValid = 1'b0;
    chk("b2b_accept_gap", 32'(acc_b - acc), 32'd5);
    last_data = 32'h5566_7788;
    push(1'b0, 1'b0, 32'h5566_7788, acc_b + 4);
    wait_drain();
    memReady = 1'b0; memRvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
